// File: rtl/rc_mc_fork.sv
// Multicast route compute and fork: registered header capture, first replica one cycle later, one replica per cycle, out_* held while out_ready is low.
// Optional macro MC_INJECT_EN: accept local injection (in_dir == NUM_DIR) with every direction port treated as straight.
module rc_mc_fork #(
  parameter int NUM_NODE = 16,
  parameter int NUM_DIR  = 4,
  parameter int NUM_PORT = NUM_DIR + 1,
  parameter int PIDX_W   = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_NODE-1:0]          in_dst,
  input  logic [PIDX_W-1:0]            in_dir,
  input  logic                         in_ltb,
  input  logic                         in_rtb,
  input  logic [NUM_DIR*NUM_NODE-1:0]  mask_straight,
  input  logic [NUM_DIR*NUM_NODE-1:0]  mask_left,
  input  logic [NUM_DIR*NUM_NODE-1:0]  mask_right,
  input  logic [NUM_DIR*NUM_NODE-1:0]  mask_local,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PIDX_W-1:0]            out_port,
  output logic [NUM_NODE-1:0]          out_dst,
  output logic                         out_ltb,
  output logic                         out_rtb,
  output logic                         out_last,
  output logic                         err_nodst
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [NUM_PORT-1:0]   r_pend;
  logic [NUM_NODE-1:0]   r_sub [NUM_PORT];
  logic [NUM_PORT-1:0]   r_str;
  logic                  r_ltb;
  logic                  r_rtb;
  logic                  r_err;

  logic [NUM_NODE-1:0]   w_ms   [NUM_DIR];
  logic [NUM_NODE-1:0]   w_mlf  [NUM_DIR];
  logic [NUM_NODE-1:0]   w_mr   [NUM_DIR];
  logic [NUM_NODE-1:0]   w_mloc [NUM_DIR];
  logic [NUM_NODE-1:0]   w_raw  [NUM_PORT];
  logic [NUM_NODE-1:0]   w_sub  [NUM_PORT];
  logic [NUM_NODE-1:0]   w_claim;
  logic [NUM_PORT-1:0]   w_pend;
  logic [NUM_PORT-1:0]   w_str;
  logic                  w_inject;
  int                    w_di;

  logic [PIDX_W-1:0]     w_sel;
  logic [NUM_PORT-1:0]   w_sel_oh;
  logic [NUM_NODE-1:0]   w_dst;
  logic                  w_str_sel;
  logic                  w_last;
  logic                  w_cap;
  logic                  w_acc;

  for (genvar d = 0; d < NUM_DIR; d++) begin : g_slice
    assign w_ms[d]   = mask_straight[d*NUM_NODE +: NUM_NODE];
    assign w_mlf[d]  = mask_left[d*NUM_NODE +: NUM_NODE];
    assign w_mr[d]   = mask_right[d*NUM_NODE +: NUM_NODE];
    assign w_mloc[d] = mask_local[d*NUM_NODE +: NUM_NODE];
  end

`ifdef MC_INJECT_EN
  assign w_inject = (in_dir == PIDX_W'(NUM_DIR));
`else
  assign w_inject = 1'b0;
`endif

  assign w_di = int'(in_dir);

  // Raw per-port subsets, then dedup in claim order local, 0..NUM_DIR-1.
  always_comb begin
    w_str   = '0;
    w_pend  = '0;
    w_claim = '0;
    for (int p = 0; p < NUM_PORT; p++) begin
      w_raw[p] = '0;
      w_sub[p] = '0;
    end
    if (w_inject) begin
      for (int p = 0; p < NUM_DIR; p++) begin
        w_raw[p] = in_dst & (w_ms[p] | (w_mlf[p] & {NUM_NODE{in_ltb}})
                                     | (w_mr[p]  & {NUM_NODE{in_rtb}}));
        w_str[p] = 1'b1;
      end
      for (int d = 0; d < NUM_DIR; d++) begin
        w_raw[NUM_DIR] = w_raw[NUM_DIR] | (in_dst & w_mloc[d]);
      end
    end else if (w_di < NUM_DIR) begin
      for (int p = 0; p < NUM_DIR; p++) begin
        if (p == (w_di + 2) % NUM_DIR) begin
          w_raw[p] = in_dst & (w_ms[p] | (w_mlf[p] & {NUM_NODE{in_ltb}})
                                       | (w_mr[p]  & {NUM_NODE{in_rtb}}));
          w_str[p] = 1'b1;
        end else if (p == (w_di + 1) % NUM_DIR) begin
          w_raw[p] = in_dst & w_ms[p] & {NUM_NODE{in_ltb}};
        end else if (p == (w_di + 3) % NUM_DIR) begin
          w_raw[p] = in_dst & w_ms[p] & {NUM_NODE{in_rtb}};
        end
      end
      for (int d = 0; d < NUM_DIR; d++) begin
        if (d == w_di) begin
          w_raw[NUM_DIR] = in_dst & w_mloc[d];
        end
      end
    end
    w_sub[NUM_DIR] = w_raw[NUM_DIR];
    w_claim        = w_raw[NUM_DIR];
    for (int p = 0; p < NUM_DIR; p++) begin
      w_sub[p] = w_raw[p] & ~w_claim;
      w_claim  = w_claim | w_raw[p];
    end
    for (int p = 0; p < NUM_PORT; p++) begin
      w_pend[p] = |w_sub[p];
    end
  end

  // Local port wins, then the lowest pending direction.
  always_comb begin
    w_sel     = '0;
    w_sel_oh  = '0;
    w_dst     = '0;
    w_str_sel = 1'b0;
    for (int p = NUM_DIR - 1; p >= 0; p--) begin
      if (r_pend[p]) begin
        w_sel     = PIDX_W'(p);
        w_sel_oh  = NUM_PORT'(1) << p;
        w_dst     = r_sub[p];
        w_str_sel = r_str[p];
      end
    end
    if (r_pend[NUM_DIR]) begin
      w_sel     = PIDX_W'(NUM_DIR);
      w_sel_oh  = NUM_PORT'(1) << NUM_DIR;
      w_dst     = r_sub[NUM_DIR];
      w_str_sel = 1'b0;
    end
  end

  assign w_last = (r_pend != '0) && ((r_pend & (r_pend - NUM_PORT'(1))) == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    w_acc       = 1'b0;
    in_ready    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_cap       = 1'b1;
          w_state_nxt = (w_pend != '0) ? EMIT : IDLE;
        end
      end
      EMIT: begin
        w_acc = out_ready;
        if (out_ready && w_last) begin
          in_ready = 1'b1;
          if (in_valid) begin
            w_cap       = 1'b1;
            w_state_nxt = (w_pend != '0) ? EMIT : IDLE;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_str  <= '0;
      r_ltb  <= 1'b0;
      r_rtb  <= 1'b0;
      r_err  <= 1'b0;
      for (int p = 0; p < NUM_PORT; p++) begin
        r_sub[p] <= '0;
      end
    end else begin
      r_err <= w_cap && (w_pend == '0);
      if (w_cap) begin
        r_pend <= w_pend;
        r_str  <= w_str;
        r_ltb  <= in_ltb;
        r_rtb  <= in_rtb;
        for (int p = 0; p < NUM_PORT; p++) begin
          r_sub[p] <= w_sub[p];
        end
      end else if (w_acc) begin
        r_pend <= r_pend & ~w_sel_oh;
      end
    end
  end

  assign out_valid = (r_state == EMIT);
  assign out_port  = w_sel;
  assign out_dst   = w_dst;
  assign out_ltb   = out_valid & w_str_sel & r_ltb;
  assign out_rtb   = out_valid & w_str_sel & r_rtb;
  assign out_last  = out_valid & w_last;
  assign err_nodst = r_err;

endmodule

// File: tb/tb_rc_mc_fork.sv
// Bench for rc_mc_fork: directed vector table, hand-written corner sequences, randomized headers against a per-node reference model.
module tb_rc_mc_fork;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_dst;
  logic [2:0]  in_dir;
  logic        in_ltb;
  logic        in_rtb;
  logic [63:0] mask_straight;
  logic [63:0] mask_left;
  logic [63:0] mask_right;
  logic [63:0] mask_local;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_port;
  logic [15:0] out_dst;
  logic        out_ltb;
  logic        out_rtb;
  logic        out_last;
  logic        err_nodst;

  rc_mc_fork dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dst(in_dst), .in_dir(in_dir), .in_ltb(in_ltb), .in_rtb(in_rtb),
    .mask_straight(mask_straight), .mask_left(mask_left),
    .mask_right(mask_right), .mask_local(mask_local),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_port(out_port), .out_dst(out_dst),
    .out_ltb(out_ltb), .out_rtb(out_rtb),
    .out_last(out_last), .err_nodst(err_nodst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  port;
    logic [15:0] dst;
    logic        ltb;
    logic        rtb;
  } rep_t;

  typedef struct {
    logic [15:0] dst;
    logic [2:0]  dir;
    logic        ltb;
    logic        rtb;
    logic [63:0] ms;
    logic [63:0] mlf;
    logic [63:0] mloc;
    int          n;
    logic [2:0]  p0;
    logic [15:0] d0;
    logic        l0;
    logic        r0;
    logic [2:0]  p1;
    logic [15:0] d1;
    logic        l1;
    logic        r1;
  } vec_t;

  rep_t exp_q[$];
  vec_t vecs[9];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-node reference: each destination goes to the first port in claim order that accepts it.
  task automatic build_expect(input logic [15:0] hdst, input logic [2:0] hdir,
                              input logic hltb, input logic hrtb);
    logic [15:0] sub [5];
    int          di;
    int          t;
    bit          s, l, r, taken, acc;
    int          order [5];
    di = int'(hdir);
    order = '{4, 0, 1, 2, 3};
    for (int k = 0; k < 5; k++) sub[k] = '0;
    exp_q.delete();
    if (di < 4) begin
      for (int n = 0; n < 16; n++) begin
        if (hdst[n]) begin
          taken = 1'b0;
          if (mask_local[di*16 + n]) begin
            sub[4][n] = 1'b1;
            taken = 1'b1;
          end
          for (int p = 0; p < 4; p++) begin
            if (!taken) begin
              t = (p - di + 4) % 4;
              s = mask_straight[p*16 + n];
              l = mask_left[p*16 + n];
              r = mask_right[p*16 + n];
              case (t)
                2:       acc = s | (l & hltb) | (r & hrtb);
                1:       acc = s & hltb;
                3:       acc = s & hrtb;
                default: acc = 1'b0;
              endcase
              if (acc) begin
                sub[p][n] = 1'b1;
                taken = 1'b1;
              end
            end
          end
        end
      end
    end
    for (int k = 0; k < 5; k++) begin
      if (sub[order[k]] != 16'h0) begin
        if (order[k] != 4 && ((order[k] - di + 4) % 4) == 2)
          exp_q.push_back('{3'(order[k]), sub[order[k]], hltb, hrtb});
        else
          exp_q.push_back('{3'(order[k]), sub[order[k]], 1'b0, 1'b0});
      end
    end
  endtask

  // Entered and left one time unit after a rising edge, with the DUT idle.
  task automatic run_hdr(input logic [15:0] hdst, input logic [2:0] hdir,
                         input logic hltb, input logic hrtb,
                         input int stall, input bit rnd, input bit scramble);
    int   cyc;
    bit   acc;
    rep_t e;
    in_valid  = 1'b1;
    in_dst    = hdst;
    in_dir    = hdir;
    in_ltb    = hltb;
    in_rtb    = hrtb;
    out_ready = 1'b0;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_dst   = 16'($urandom);
    in_dir   = 3'($urandom);
    if (scramble) begin
      mask_straight = {$urandom, $urandom};
      mask_left     = {$urandom, $urandom};
      mask_right    = {$urandom, $urandom};
      mask_local    = {$urandom, $urandom};
    end
    if (exp_q.size() == 0) begin
      @(negedge clk);
      chk("err_pulse", err_nodst, 1);
      chk("err_no_valid", out_valid, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("err_clear", err_nodst, 0);
      chk("err_idle_valid", out_valid, 0);
      chk("err_idle_ready", in_ready, 1);
      @(posedge clk); #1;
    end else begin
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 200) begin
        if (cyc < stall) out_ready = 1'b0;
        else if (rnd)    out_ready = 1'($urandom);
        else             out_ready = 1'b1;
        @(negedge clk);
        e = exp_q[0];
        chk("rep_valid", out_valid, 1);
        chk("rep_port", out_port, e.port);
        chk("rep_dst", out_dst, e.dst);
        chk("rep_ltb", out_ltb, e.ltb);
        chk("rep_rtb", out_rtb, e.rtb);
        chk("rep_last", out_last, (exp_q.size() == 1));
        chk("rep_in_ready", in_ready, out_ready && (exp_q.size() == 1));
        chk("rep_no_err", err_nodst, 0);
        acc = out_valid && out_ready;
        @(posedge clk); #1;
        if (acc) void'(exp_q.pop_front());
        cyc++;
      end
      chk("drain_left", exp_q.size(), 0);
      out_ready = 1'b0;
      @(negedge clk);
      chk("done_valid", out_valid, 0);
      chk("done_ready", in_ready, 1);
      @(posedge clk); #1;
    end
  endtask

  task automatic load_vec(input vec_t v);
    mask_straight = v.ms;
    mask_left     = v.mlf;
    mask_right    = '0;
    mask_local    = v.mloc;
    exp_q.delete();
    if (v.n > 0) exp_q.push_back('{v.p0, v.d0, v.l0, v.r0});
    if (v.n > 1) exp_q.push_back('{v.p1, v.d1, v.l1, v.r1});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'h0011, 3'd2, 1'b0, 1'b0, 64'h0000_0000_0000_0001, 64'h0, 64'h0000_0010_0000_0000,
                2, 3'd4, 16'h0010, 1'b0, 1'b0, 3'd0, 16'h0001, 1'b0, 1'b0};
    vecs[1] = '{16'h0100, 3'd3, 1'b1, 1'b0, 64'h0000_0000_0000_0100, 64'h0, 64'h0,
                1, 3'd0, 16'h0100, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0};
    vecs[2] = '{16'h0100, 3'd3, 1'b0, 1'b0, 64'h0000_0000_0000_0100, 64'h0, 64'h0,
                0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0};
    vecs[3] = '{16'h0020, 3'd3, 1'b0, 1'b1, 64'h0000_0020_0020_0000, 64'h0, 64'h0,
                1, 3'd1, 16'h0020, 1'b0, 1'b1, 3'd0, 16'h0, 1'b0, 1'b0};
    vecs[4] = '{16'hFFFF, 3'd5, 1'b1, 1'b1, {64{1'b1}}, {64{1'b1}}, {64{1'b1}},
                0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0};
    vecs[5] = '{16'h0004, 3'd1, 1'b1, 1'b1, 64'h0000_0000_0004_0000, 64'h0, 64'h0,
                0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0};
    vecs[6] = '{16'h00FF, 3'd0, 1'b1, 1'b1, 64'h0000_000F_00F0_0000, 64'h0, 64'h0,
                2, 3'd1, 16'h00F0, 1'b0, 1'b0, 3'd2, 16'h000F, 1'b1, 1'b1};
    vecs[7] = '{16'h1000, 3'd2, 1'b1, 1'b0, 64'h0, 64'h0000_0000_0000_1000, 64'h0,
                1, 3'd0, 16'h1000, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0};
    vecs[8] = '{16'hFFFF, 3'd4, 1'b1, 1'b1, {64{1'b1}}, {64{1'b1}}, {64{1'b1}},
                0, 3'd0, 16'h0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0; in_dst = '0; in_dir = '0; in_ltb = 1'b0; in_rtb = 1'b0;
    mask_straight = '0; mask_left = '0; mask_right = '0; mask_local = '0;
    out_ready = 1'b0;
    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_err", err_nodst, 0);
    chk("rst_dst", out_dst, 0);
    chk("rst_port", out_port, 0);
    chk("rst_last", out_last, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int k = 0; k < 9; k++) begin
      load_vec(vecs[k]);
      run_hdr(vecs[k].dst, vecs[k].dir, vecs[k].ltb, vecs[k].rtb, 0, 1'b0, 1'b0);
    end

    // Three-cycle stall on the first replica, masks scrambled while in flight.
    load_vec(vecs[0]);
    run_hdr(vecs[0].dst, vecs[0].dir, vecs[0].ltb, vecs[0].rtb, 3, 1'b0, 1'b1);

    // Back-to-back headers: B is captured on the edge that accepts A's last replica.
    mask_straight = 64'h0000_0000_0000_0001;
    mask_left = '0; mask_right = '0;
    mask_local = 64'h0000_0010_0000_0000;
    in_valid = 1'b1; in_dst = 16'h0011; in_dir = 3'd2; in_ltb = 1'b0; in_rtb = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("b2b_a_ready", in_ready, 1);
    @(posedge clk); #1;
    in_dst = 16'h0010;
    @(negedge clk);
    chk("b2b_a0_port", out_port, 4);
    chk("b2b_a0_last", out_last, 0);
    chk("b2b_a0_in_ready", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_a1_port", out_port, 0);
    chk("b2b_a1_dst", out_dst, 16'h0001);
    chk("b2b_a1_last", out_last, 1);
    chk("b2b_a1_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_b_valid", out_valid, 1);
    chk("b2b_b_port", out_port, 4);
    chk("b2b_b_dst", out_dst, 16'h0010);
    chk("b2b_b_last", out_last, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_end_valid", out_valid, 0);
    @(posedge clk); #1;

    // Asynchronous reset with two replicas still pending.
    mask_straight = 64'h0000_000F_00F0_0000;
    mask_local    = 64'h0000_0000_0000_0100;
    in_valid = 1'b1; in_dst = 16'h01FF; in_dir = 3'd0; in_ltb = 1'b1; in_rtb = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_mid_first", out_port, 4);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("rst_mid_second", out_port, 1);
    chk("rst_mid_not_last", out_last, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_dst", out_dst, 0);
    chk("arst_port", out_port, 0);
    chk("arst_ltb", out_ltb, 0);
    chk("arst_in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_valid", out_valid, 0);
      chk("post_rst_ready", in_ready, 1);
      @(posedge clk); #1;
    end

    // Randomized headers against the reference model.
    for (int i = 0; i < 80; i++) begin
      logic [15:0] rd;
      logic [2:0]  rdir;
      logic        rl, rr;
      mask_straight = {$urandom, $urandom} & {$urandom, $urandom};
      mask_left     = {$urandom, $urandom} & {$urandom, $urandom};
      mask_right    = {$urandom, $urandom} & {$urandom, $urandom};
      mask_local    = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      rd   = 16'($urandom);
      rdir = 3'($urandom_range(0, 5));
      rl   = 1'($urandom);
      rr   = 1'($urandom);
      build_expect(rd, rdir, rl, rr);
      run_hdr(rd, rdir, rl, rr, 0, 1'b1, (i % 4) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
